// File: rtl/eth_rx_frame_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_frame_arb_pkg
// Description : Shared definitions for the Ethernet RX frame arbiter: FSM
//               state encodings, a clog2 helper and the default frame
//               length limit.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_rx_frame_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DROP = 2'd2
   } arb_state_t;

   // Default number of beats allowed per frame before forced truncation
   localparam int c_DEFAULT_MAX_BEATS = 190;

   // Ceiling log2, elaboration-time helper for index/counter widths
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rx_frame_arb_axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : axis_out_reg
// Description : Single-stage AXI-stream register (tdata/tkeep/tlast/tuser)
//               with ready back-propagation. Contents are held stable while
//               the downstream side stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_out_reg #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_tdata,
   input  logic [KEEP_WIDTH-1:0] in_tkeep,
   input  logic                  in_tvalid,
   output logic                  in_tready,
   input  logic                  in_tlast,
   input  logic                  in_tuser,
   output logic [DATA_WIDTH-1:0] out_tdata,
   output logic [KEEP_WIDTH-1:0] out_tkeep,
   output logic                  out_tvalid,
   input  logic                  out_tready,
   output logic                  out_tlast,
   output logic                  out_tuser
);

   logic [DATA_WIDTH-1:0] r_tdata;
   logic [KEEP_WIDTH-1:0] r_tkeep;
   logic                  r_tvalid;
   logic                  r_tlast;
   logic                  r_tuser;

   // Register can take a new beat when empty or when its beat leaves this cycle
   assign in_tready  = !r_tvalid || out_tready;

   assign out_tdata  = r_tdata;
   assign out_tkeep  = r_tkeep;
   assign out_tvalid = r_tvalid;
   assign out_tlast  = r_tlast;
   assign out_tuser  = r_tuser;

   // Load on upstream handshake, otherwise drain valid on downstream handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tdata  <= '0;
         r_tkeep  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tuser  <= 1'b0;
      end else if (in_tvalid && in_tready) begin
         r_tdata  <= in_tdata;
         r_tkeep  <= in_tkeep;
         r_tvalid <= 1'b1;
         r_tlast  <= in_tlast;
         r_tuser  <= in_tuser;
      end else if (out_tready) begin
         r_tvalid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/eth_rx_frame_arb.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_frame_arb
// Description : Frame-granular round-robin arbiter sharing one AXI-stream
//               Ethernet RX path among S_COUNT input streams. Grant is held
//               for a whole frame; frames longer than MAX_BEATS are cut,
//               marked bad, and their remainder is discarded.
//               Optional macro ETH_RX_ARB_STATS_EN adds saturating
//               frame_count / trunc_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_frame_arb
   import eth_rx_frame_arb_pkg::*;
#(
   parameter int S_COUNT    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BEATS  = c_DEFAULT_MAX_BEATS,
   localparam int KEEP_WIDTH = DATA_WIDTH / 8,
   localparam int IDX_W      = (clog2(S_COUNT) < 1) ? 1 : clog2(S_COUNT)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [S_COUNT-1:0]            s_axis_tvalid,
   output logic [S_COUNT-1:0]            s_axis_tready,
   input  logic [S_COUNT-1:0]            s_axis_tlast,
   input  logic [S_COUNT-1:0]            s_axis_tuser,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tuser,
   output logic                          grant_valid,
   output logic [IDX_W-1:0]              grant_idx
`ifdef ETH_RX_ARB_STATS_EN
   ,
   output logic [31:0]                   frame_count,
   output logic [31:0]                   trunc_count
`endif
);

   localparam int c_CNT_W = clog2(MAX_BEATS);

   arb_state_t            r_state;
   logic [IDX_W-1:0]      r_rr_ptr;
   logic [IDX_W-1:0]      r_grant_idx;
   logic                  r_grant_valid;
   logic [c_CNT_W-1:0]    r_beat_cnt;

   logic [DATA_WIDTH-1:0] w_sel_tdata;
   logic [KEEP_WIDTH-1:0] w_sel_tkeep;
   logic                  w_sel_tvalid;
   logic                  w_sel_tlast;
   logic                  w_sel_tuser;
   logic                  w_sel_ready;
   logic                  w_out_ready;
   logic                  w_accept;
   logic                  w_at_limit;
   logic                  w_trunc_beat;
   logic                  w_any_req;
   logic                  w_found_hi;
   logic [IDX_W-1:0]      w_pick_hi;
   logic [IDX_W-1:0]      w_pick_lo;
   logic [IDX_W-1:0]      w_pick;
   logic [IDX_W-1:0]      w_next_ptr;
   logic                  w_out_tvalid;
   logic                  w_out_tlast;

   assign grant_valid   = r_grant_valid;
   assign grant_idx     = r_grant_idx;
   assign m_axis_tvalid = w_out_tvalid;
   assign m_axis_tlast  = w_out_tlast;

   // Route the owning port's stream onto the shared path
   always_comb begin
      w_sel_tdata  = '0;
      w_sel_tkeep  = '0;
      w_sel_tvalid = 1'b0;
      w_sel_tlast  = 1'b0;
      w_sel_tuser  = 1'b0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (r_grant_idx == IDX_W'(i)) begin
            w_sel_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            w_sel_tkeep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            w_sel_tvalid = s_axis_tvalid[i];
            w_sel_tlast  = s_axis_tlast[i];
            w_sel_tuser  = s_axis_tuser[i];
         end
      end
   end

   // Owner follows the output register in XFER, always sinks in DROP, nothing in IDLE
   assign w_sel_ready = (r_state == ST_XFER) ? w_out_ready : (r_state == ST_DROP);
   assign w_accept    = w_sel_tvalid && w_sel_ready;

   // Only the granted port ever sees ready
   always_comb begin
      s_axis_tready = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (r_grant_idx == IDX_W'(i)) begin
            s_axis_tready[i] = w_sel_ready;
         end
      end
   end

   // Last permitted beat without tlast gets cut and marked bad
   assign w_at_limit   = (r_beat_cnt == c_CNT_W'(MAX_BEATS - 1));
   assign w_trunc_beat = (r_state == ST_XFER) && w_at_limit && !w_sel_tlast;

   // Round-robin pick: lowest requester at/after rr_ptr, else lowest below it
   always_comb begin
      w_any_req  = |s_axis_tvalid;
      w_found_hi = 1'b0;
      w_pick_hi  = '0;
      w_pick_lo  = '0;
      for (int i = S_COUNT - 1; i >= 0; i--) begin
         if (s_axis_tvalid[i]) begin
            if (IDX_W'(i) >= r_rr_ptr) begin
               w_found_hi = 1'b1;
               w_pick_hi  = IDX_W'(i);
            end else begin
               w_pick_lo  = IDX_W'(i);
            end
         end
      end
      w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
   end

   assign w_next_ptr = (r_grant_idx == IDX_W'(S_COUNT - 1)) ? '0 : r_grant_idx + IDX_W'(1);

   // Arbitration FSM: grant in IDLE, forward in XFER, discard tail in DROP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_rr_ptr      <= '0;
         r_grant_idx   <= '0;
         r_grant_valid <= 1'b0;
         r_beat_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_grant_idx   <= w_pick;
                  r_grant_valid <= 1'b1;
                  r_state       <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (w_accept) begin
                  if (w_sel_tlast) begin
                     r_beat_cnt    <= '0;
                     r_rr_ptr      <= w_next_ptr;
                     r_grant_valid <= 1'b0;
                     r_state       <= ST_IDLE;
                  end else if (w_at_limit) begin
                     r_beat_cnt    <= '0;
                     r_state       <= ST_DROP;
                  end else begin
                     r_beat_cnt    <= r_beat_cnt + c_CNT_W'(1);
                  end
               end
            end
            ST_DROP: begin
               if (w_accept && w_sel_tlast) begin
                  r_rr_ptr      <= w_next_ptr;
                  r_grant_valid <= 1'b0;
                  r_state       <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   axis_out_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .KEEP_WIDTH (KEEP_WIDTH)
   ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .in_tdata   (w_sel_tdata),
      .in_tkeep   (w_sel_tkeep),
      .in_tvalid  ((r_state == ST_XFER) && w_sel_tvalid),
      .in_tready  (w_out_ready),
      .in_tlast   (w_sel_tlast || w_trunc_beat),
      .in_tuser   (w_sel_tuser || w_trunc_beat),
      .out_tdata  (m_axis_tdata),
      .out_tkeep  (m_axis_tkeep),
      .out_tvalid (w_out_tvalid),
      .out_tready (m_axis_tready),
      .out_tlast  (w_out_tlast),
      .out_tuser  (m_axis_tuser)
   );

`ifdef ETH_RX_ARB_STATS_EN
   logic [31:0] r_frame_count;
   logic [31:0] r_trunc_count;

   assign frame_count = r_frame_count;
   assign trunc_count = r_trunc_count;

   // Saturating counters: frames leaving on m_axis, and truncation events
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_count <= '0;
         r_trunc_count <= '0;
      end else begin
         if (w_out_tvalid && m_axis_tready && w_out_tlast && (r_frame_count != '1)) begin
            r_frame_count <= r_frame_count + 32'd1;
         end
         if (w_trunc_beat && w_accept && (r_trunc_count != '1)) begin
            r_trunc_count <= r_trunc_count + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire
